mod_counter: RTL and testbench

- Parametrised, programmable-modulus up/down counter; successor to the fixed 4-bit wrap counter in the serial-com datapath.
- Used for bit/sample counting and baud-tick generation.
- Adds:
  - run-time limit
  - direction control
  - wrap or saturate mode
  - synchronous clear and load
  - built-in prescaler
  - terminal-count, wrap-pulse and sticky-overflow outputs
- Defaults (WIDTH=4, limit=15, up, wrap, PRESCALE=1) reproduce the legacy 0..15 wrap counter exactly.

---
 rtl/mod_counter_pkg.sv | 28 ++
 rtl/mod_counter_tick_prescaler.sv | 43 ++++
 rtl/mod_counter.sv | 99 +++++++++
 tb/tb_mod_counter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mod_counter_pkg.sv
// Shared types and helpers for the programmable-modulus counter.
package mod_counter_pkg;

   // Behaviour when a step hits the count boundary.
   typedef enum logic {
      MODE_WRAP = 1'b0,
      MODE_SAT  = 1'b1
   } mode_e;

   // Count direction.
   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

   // Bits needed to hold 0..n-1, never less than one bit.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) begin
            r = i + 1;
         end
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage : mod_counter_pkg

// File: rtl/mod_counter_tick_prescaler.sv
// Divides the enable stream by PRESCALE: tick is high on the last
// enabled cycle of each PRESCALE-cycle period.
module tick_prescaler
   import mod_counter_pkg::*;
#(
   parameter int PRESCALE = 1,
   parameter int PS_W     = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic sync_clr,
   output logic tick
);

   localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

   logic [PS_W-1:0] cnt_q;
   logic [PS_W-1:0] cnt_d;

   // With PRESCALE==1 LAST is 0 and the count never leaves 0, so tick is constant 1.
   assign tick = (cnt_q == LAST);

   // Next prescaler phase: restart on clear/load, advance only while enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (sync_clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PS_W'(1);
      end
   end

   // Prescaler phase register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : tick_prescaler

// File: rtl/mod_counter.sv
// Programmable-modulus up/down counter with wrap/saturate boundary handling,
// synchronous clear/load, built-in prescaler and boundary status outputs.
module mod_counter
   import mod_counter_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             up,
   input  logic [WIDTH-1:0] limit,
   input  logic             sat_mode,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap_pulse,
   output logic             ovf_sticky
);

   localparam int PS_W = clog2_min1(PRESCALE);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic             wrap_q;
   logic             wrap_d;
   logic             ovf_q;
   logic             ovf_d;
   logic             ps_tick;
   logic             step;
   logic             at_bound;
   dir_e             dir;
   mode_e            mode;

   assign dir  = dir_e'(up);
   assign mode = mode_e'(sat_mode);

   tick_prescaler #(
      .PRESCALE (PRESCALE),
      .PS_W     (PS_W)
   ) u_prescaler (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .sync_clr (clr | load),
      .tick     (ps_tick)
   );

   assign step = en & ps_tick;

   // Up uses >= so a count left above a lowered limit is treated as a boundary.
   assign at_bound = (dir == DIR_UP) ? (q_q >= limit) : (q_q == '0);

   assign tc         = (dir == DIR_UP) ? (q_q == limit) : (q_q == '0);
   assign q          = q_q;
   assign wrap_pulse = wrap_q;
   assign ovf_sticky = ovf_q;

   // Next count and flags, priority clear > load > step.
   always_comb begin
      q_d    = q_q;
      wrap_d = 1'b0;
      ovf_d  = ovf_q;
      if (clr) begin
         q_d   = '0;
         ovf_d = 1'b0;
      end else if (load) begin
         q_d = (load_val > limit) ? limit : load_val;
      end else if (step) begin
         if (!at_bound) begin
            q_d = (dir == DIR_UP) ? q_q + WIDTH'(1) : q_q - WIDTH'(1);
         end else if (mode == MODE_SAT) begin
            q_d   = (dir == DIR_UP) ? limit : '0;
            ovf_d = 1'b1;
         end else begin
            q_d    = (dir == DIR_UP) ? '0 : limit;
            wrap_d = 1'b1;
            ovf_d  = 1'b1;
         end
      end
   end

   // Count and status registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q    <= '0;
         wrap_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         q_q    <= q_d;
         wrap_q <= wrap_d;
         ovf_q  <= ovf_d;
      end
   end

endmodule : mod_counter

// File: tb/tb_mod_counter.sv
// Drives two counters (PRESCALE 1 and 4) with identical inputs and checks
// each against an arithmetic reference model after every clock edge.
module tb_mod_counter;

   logic       clk;
   logic       rst;
   logic       en;
   logic       clr;
   logic       load;
   logic [3:0] load_val;
   logic       up;
   logic [3:0] limit;
   logic       sat_mode;

   logic [3:0] q_w    [2];
   logic       tc_w   [2];
   logic       wrap_w [2];
   logic       ovf_w  [2];

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Reference model state per instance.
   int mq  [2];
   int mps [2];
   int mw  [2];
   int mo  [2];

   mod_counter #(.WIDTH(4), .PRESCALE(1)) dut_p1 (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load),
      .load_val(load_val), .up(up), .limit(limit), .sat_mode(sat_mode),
      .q(q_w[0]), .tc(tc_w[0]), .wrap_pulse(wrap_w[0]), .ovf_sticky(ovf_w[0])
   );

   mod_counter #(.WIDTH(4), .PRESCALE(4)) dut_p4 (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load),
      .load_val(load_val), .up(up), .limit(limit), .sat_mode(sat_mode),
      .q(q_w[1]), .tc(tc_w[1]), .wrap_pulse(wrap_w[1]), .ovf_sticky(ovf_w[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int ps_of(input int k);
      return (k == 0) ? 1 : 4;
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         mq[k] = 0; mps[k] = 0; mw[k] = 0; mo[k] = 0;
      end
   endfunction

   // One clock edge of the counter rules, using plain integer arithmetic.
   function automatic void model_edge(input int k);
      int lim;
      int p;
      bit fire;
      lim = int'(limit);
      p   = ps_of(k);
      mw[k] = 0;
      if (clr) begin
         mq[k] = 0; mps[k] = 0; mo[k] = 0;
      end else if (load) begin
         mq[k]  = (int'(load_val) > lim) ? lim : int'(load_val);
         mps[k] = 0;
      end else if (en) begin
         fire   = (mps[k] == p - 1);
         mps[k] = (mps[k] + 1) % p;
         if (fire) begin
            if (up) begin
               if (mq[k] < lim) mq[k] = mq[k] + 1;
               else begin
                  mo[k] = 1;
                  if (sat_mode) mq[k] = lim;
                  else begin mq[k] = 0; mw[k] = 1; end
               end
            end else begin
               if (mq[k] > 0) mq[k] = mq[k] - 1;
               else begin
                  mo[k] = 1;
                  if (sat_mode) mq[k] = 0;
                  else begin mq[k] = lim; mw[k] = 1; end
               end
            end
         end
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      assert (act === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, act, exp);
      end
   endtask

   task automatic check_all();
      int etc;
      for (int k = 0; k < 2; k++) begin
         etc = up ? int'(mq[k] == int'(limit)) : int'(mq[k] == 0);
         chk($sformatf("q[%0d]", k),    32'(q_w[k]),    32'(mq[k]));
         chk($sformatf("tc[%0d]", k),   32'(tc_w[k]),   32'(etc));
         chk($sformatf("wrap[%0d]", k), 32'(wrap_w[k]), 32'(mw[k]));
         chk($sformatf("ovf[%0d]", k),  32'(ovf_w[k]),  32'(mo[k]));
      end
   endtask

   // Advance one clock: update model, wait for edge, sample 1 time unit later.
   task automatic cycle();
      for (int k = 0; k < 2; k++) model_edge(k);
      @(posedge clk);
      #1;
      cyc++;
      check_all();
      $display("cyc=%0d en=%0b clr=%0b ld=%0b up=%0b sat=%0b lim=%0d | q1=%0d w1=%0b o1=%0b | q4=%0d w4=%0b o4=%0b",
               cyc, en, clr, load, up, sat_mode, limit,
               q_w[0], wrap_w[0], ovf_w[0], q_w[1], wrap_w[1], ovf_w[1]);
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0; load_val = 4'd0;
      up = 1'b1; limit = 4'd15; sat_mode = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Legacy behaviour: free-running 0..15 wrap.
      en = 1'b1;
      cycles(20);

      // Saturate at 9 going up, then count down.
      clr = 1'b1; cycle(); clr = 1'b0;
      limit = 4'd9; sat_mode = 1'b1; up = 1'b1;
      cycles(12);
      up = 1'b0;
      cycles(6);

      // Prescaled counting with an enable gap mid-period.
      clr = 1'b1; cycle(); clr = 1'b0;
      up = 1'b1; sat_mode = 1'b0; limit = 4'd15;
      cycles(6);
      en = 1'b0; cycles(3);
      en = 1'b1; cycles(6);

      // Load clamping, clear over load, and down-wrap from zero.
      load = 1'b1; load_val = 4'd5; limit = 4'd9; cycle();
      load_val = 4'd12; cycle();
      clr = 1'b1; cycle();
      clr = 1'b0; load = 1'b0;
      up = 1'b0; sat_mode = 1'b0;
      cycles(5);

      // Limit lowered below the current count, wrap then saturate.
      for (int m = 0; m < 2; m++) begin
         up = 1'b1; limit = 4'd15; sat_mode = m[0];
         load = 1'b1; load_val = 4'd12; cycle(); load = 1'b0;
         limit = 4'd7;
         cycles(5);
      end

      // Limit of zero in both directions.
      limit = 4'd0; sat_mode = 1'b0; up = 1'b1; cycles(5);
      up = 1'b0; cycles(5);

      // Asynchronous reset mid-period.
      limit = 4'd15; up = 1'b1;
      load = 1'b1; load_val = 4'd6; cycle(); load = 1'b0;
      cycles(2);
      @(negedge clk);
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      #1;
      rst = 1'b0;
      cycles(9);

      // Randomised operation.
      for (int i = 0; i < 400; i++) begin
         en       = ($urandom_range(0, 3) != 0);
         clr      = ($urandom_range(0, 40) == 0);
         load     = ($urandom_range(0, 15) == 0);
         load_val = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 20) == 0) limit = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 10) == 0) up = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 15) == 0) sat_mode = 1'($urandom_range(0, 1));
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_mod_counter
